formula_stream_credit_adapter: RTL and testbench

// Upstream end of the valid-only "a**5 + 0.3*b + c" formula pipeline, which has no backpressure.

---
 rtl/formula_stream_credit_adapter_pkg.sv | 28 ++
 rtl/formula_stream_credit_adapter_fifo.sv | 59 +++++
 rtl/formula_stream_credit_adapter.sv | 120 ++++++++++++
 tb/tb_formula_stream_credit_adapter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/formula_stream_credit_adapter_pkg.sv
`default_nettype none
// ==========================================================================
// Package : formula_stream_credit_adapter_pkg
// Desc    : Shared float types and sizing helpers for the credit adapter.
// Rev     : 1.0
// ==========================================================================
package formula_stream_credit_adapter_pkg;

  localparam int FP_FLEN    = 64;
  localparam int FIFO_DEPTH = 8;

  // Counter width able to hold the value DEPTH itself.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int OCC_W = occ_width(FIFO_DEPTH);

  typedef logic [FP_FLEN-1:0] fp_t;

  typedef struct packed {
    fp_t a;
    fp_t b;
    fp_t c;
  } fp_args_t;

endpackage
`default_nettype wire

// File: rtl/formula_stream_credit_adapter_fifo.sv
`default_nettype none
// ==========================================================================
// Module : fp_result_fifo
// Desc   : First-word-fall-through result FIFO with occupancy count.
// Rev    : 1.0
// ==========================================================================
module fp_result_fifo #(
  parameter int FLEN  = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [FLEN-1:0]          wr_data,
  input  logic                     rd_en,
  output logic [FLEN-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FLEN-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr;
  logic             w_rd;

  always_comb begin
    full  = (r_count == CNT_W'(DEPTH));
    empty = (r_count == '0);
    w_wr  = wr_en & ~full;
    w_rd  = rd_en & ~empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/formula_stream_credit_adapter.sv
`default_nettype none
// ==========================================================================
// Module : formula_stream_credit_adapter
// Desc   : Credit-based ready/valid front end for the stall-free formula pipe.
// Rev    : 1.0
// ==========================================================================
module formula_stream_credit_adapter
  import formula_stream_credit_adapter_pkg::*;
#(
  parameter int FLEN  = FP_FLEN,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic [FLEN-1:0]              in_a,
  input  logic [FLEN-1:0]              in_b,
  input  logic [FLEN-1:0]              in_c,
  output logic                         pipe_arg_vld,
  output logic [FLEN-1:0]              pipe_a,
  output logic [FLEN-1:0]              pipe_b,
  output logic [FLEN-1:0]              pipe_c,
  input  logic                         pipe_res_vld,
  input  logic [FLEN-1:0]              pipe_res,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [FLEN-1:0]              out_res,
  output logic [occ_width(DEPTH)-1:0]  occupancy,
  output logic                         err_overflow,
  output logic                         err_spurious
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [OCC_W-1:0] r_reserved;
  logic [OCC_W-1:0] r_inflight;
  logic [OCC_W-1:0] w_reserved_nxt;
  logic [OCC_W-1:0] w_inflight_nxt;
  logic [OCC_W-1:0] w_count;
  logic             r_in_rdy;
  logic             r_issue_vld;
  fp_args_t         r_args;
  logic             r_err_overflow;
  logic             r_err_spurious;
  logic             w_accept;
  logic             w_pop;
  logic             w_none_inflight;
  logic             w_retire;
  logic             w_wr;
  logic             w_lost;
  logic             w_full;
  logic             w_empty;

  // A result only retires a credit when something was actually issued;
  // if it cannot be stored its reservation is released as lost.
  always_comb begin
    w_accept        = in_vld & r_in_rdy;
    w_pop           = out_rdy & ~w_empty;
    w_none_inflight = (r_inflight == '0);
    w_retire        = pipe_res_vld & ~w_none_inflight;
    w_wr            = w_retire & ~w_full;
    w_lost          = w_retire & w_full;
    w_inflight_nxt  = r_inflight + OCC_W'(w_accept) - OCC_W'(w_retire);
    w_reserved_nxt  = r_reserved + OCC_W'(w_accept) - OCC_W'(w_pop) - OCC_W'(w_lost);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reserved     <= '0;
      r_inflight     <= '0;
      r_in_rdy       <= 1'b0;
      r_issue_vld    <= 1'b0;
      r_err_overflow <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      r_reserved     <= w_reserved_nxt;
      r_inflight     <= w_inflight_nxt;
      r_in_rdy       <= (w_reserved_nxt < OCC_W'(DEPTH));
      r_issue_vld    <= w_accept;
      r_err_overflow <= r_err_overflow | (pipe_res_vld & w_full);
      r_err_spurious <= r_err_spurious | (pipe_res_vld & w_none_inflight);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_args.a <= in_a;
      r_args.b <= in_b;
      r_args.c <= in_c;
    end
  end

  fp_result_fifo #(
    .FLEN  (FLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_wr),
    .wr_data (pipe_res),
    .rd_en   (out_rdy),
    .rd_data (out_res),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign in_rdy       = r_in_rdy;
  assign pipe_arg_vld = r_issue_vld;
  assign pipe_a       = r_args.a;
  assign pipe_b       = r_args.b;
  assign pipe_c       = r_args.c;
  assign out_vld      = (w_count != '0);
  assign occupancy    = r_reserved;
  assign err_overflow = r_err_overflow;
  assign err_spurious = r_err_spurious;

endmodule
`default_nettype wire

// File: tb/tb_formula_stream_credit_adapter.sv
`default_nettype none
// ==========================================================================
// Module : tb_formula_stream_credit_adapter
// Desc   : Scoreboard bench with a fixed-latency formula pipeline model.
// Rev    : 1.0
// ==========================================================================
module tb_formula_stream_credit_adapter;

  localparam int FLEN  = 64;
  localparam int DEPTH = 8;
  localparam int L     = 5;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             in_vld;
  logic             in_rdy;
  logic [FLEN-1:0]  in_a, in_b, in_c;
  logic             pipe_arg_vld;
  logic [FLEN-1:0]  pipe_a, pipe_b, pipe_c;
  logic             pipe_res_vld;
  logic [FLEN-1:0]  pipe_res;
  logic             out_vld;
  logic             out_rdy;
  logic [FLEN-1:0]  out_res;
  logic [OCC_W-1:0] occupancy;
  logic             err_overflow;
  logic             err_spurious;
  logic             inject;

  formula_stream_credit_adapter #(.FLEN(FLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .pipe_arg_vld(pipe_arg_vld), .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c),
    .pipe_res_vld(pipe_res_vld), .pipe_res(pipe_res),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_res(out_res),
    .occupancy(occupancy), .err_overflow(err_overflow), .err_spurious(err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] formula(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c);
    real ra, rb, rc;
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    rc = $bitstoreal(c);
    return $realtobits(ra ** 5 + 0.3 * rb + rc);
  endfunction

  function automatic logic [63:0] rnd_fp();
    return $realtobits((real'($urandom_range(0, 32)) - 16.0) / 8.0);
  endfunction

  // Formula pipeline stand-in: L stages, no backpressure, shares rst_n.
  logic [L-1:0]  pv;
  logic [63:0]   pd [L];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pv <= '0;
    else begin
      pv    <= {pv[L-2:0], pipe_arg_vld};
      pd[0] <= formula(pipe_a, pipe_b, pipe_c);
      for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
    end
  end
  assign pipe_res_vld = pv[L-1] | inject;
  assign pipe_res     = pd[L-1];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard and monitor
  logic [63:0] sb_q[$];
  int          outstanding = 0;
  int          issue_cnt   = 0;
  int          pop_cnt     = 0;
  int          max_occ     = 0;
  bit          settled     = 0;
  bit          hold_prev   = 0;
  logic [63:0] hold_res;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      outstanding = 0;
      settled     = 0;
      hold_prev   = 0;
    end else begin
      chk("occupancy", occupancy, outstanding);
      if (settled) chk("in_rdy", in_rdy, (outstanding < DEPTH));
      settled = 1;
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (hold_prev) begin
        chk("hold_out_vld", out_vld, 1);
        chk("hold_out_res", out_res, hold_res);
      end
      if (pipe_arg_vld) issue_cnt++;
      if (out_vld && out_rdy) begin
        if (sb_q.size() == 0) chk("unexpected_out_vld", out_vld, 0);
        else chk("result", out_res, sb_q.pop_front());
        outstanding--;
        pop_cnt++;
      end
      if (in_vld && in_rdy) begin
        sb_q.push_back(formula(in_a, in_b, in_c));
        outstanding++;
      end
      hold_prev = out_vld & ~out_rdy;
      hold_res  = out_res;
    end
  end

  task automatic send_fixed(input real a, input real b, input real c);
    bit got = 0;
    in_a = $realtobits(a); in_b = $realtobits(b); in_c = $realtobits(c);
    in_vld = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); got = in_rdy;
      @(posedge clk); #1;
    end
    in_vld = 1'b0;
    chk("send_accepted", got, 1);
  endtask

  // rdy_pct < 0 leaves out_rdy untouched; data is held until accepted.
  task automatic stream(input int n, input int vld_pct, input int rdy_pct, input int max_cycles,
                        output int accepted, output int drops);
    bit have = 0;
    bit seen = 0;
    accepted = 0;
    drops    = 0;
    for (int cyc = 0; cyc < max_cycles && accepted < n; cyc++) begin
      if (!have) begin
        in_a = rnd_fp(); in_b = rnd_fp(); in_c = rnd_fp();
        have = 1;
      end
      in_vld = ($urandom_range(0, 99) < vld_pct);
      if (rdy_pct >= 0) out_rdy = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      if (seen && !in_rdy) drops++;
      if (in_vld && in_rdy) begin
        accepted++;
        have = 0;
        seen = 1;
      end
      @(posedge clk); #1;
    end
    in_vld = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    out_rdy = 1'b1;
    for (int i = 0; i < max_cycles && (outstanding != 0 || out_vld); i++) begin
      @(posedge clk); #1;
    end
    chk("drain_outstanding", outstanding, 0);
    chk("drain_out_vld", out_vld, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, drops, acc2, issue0, pop0, seen_vld;
    bit found;

    // Reset with in_vld asserted
    rst_n = 1'b0; in_vld = 1'b1; out_rdy = 1'b0; inject = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_pipe_arg_vld", pipe_arg_vld, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_err_overflow", err_overflow, 0);
    chk("rst_err_spurious", err_spurious, 0);
    in_vld = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_rdy", in_rdy, 1);

    // Single op: 1.0**5 + 0.3*10.0 + 0.5 = 4.5
    out_rdy = 1'b1;
    issue0  = issue_cnt;
    send_fixed(1.0, 10.0, 0.5);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = pipe_res_vld;
    end
    chk("single_res_seen", found, 1);
    chk("single_out_vld_before", out_vld, 0);
    @(negedge clk);
    chk("single_out_vld_after", out_vld, 1);
    chk("single_out_res", out_res, $realtobits(4.5));
    repeat (3) @(posedge clk);
    #1;
    chk("single_issue_count", issue_cnt - issue0, 1);

    // Back-to-back with out_rdy held high
    issue0 = issue_cnt; pop0 = pop_cnt;
    stream(100, 100, 100, 300, acc, drops);
    chk("b2b_accepted", acc, 100);
    chk("b2b_in_rdy_drops", drops, 0);
    drain(100);
    chk("b2b_results", pop_cnt - pop0, 100);
    chk("b2b_issues", issue_cnt - issue0, 100);

    // Stall: only DEPTH triples fit
    pop0 = pop_cnt;
    out_rdy = 1'b0;
    stream(20, 100, -1, 30, acc, drops);
    chk("stall_accepted", acc, DEPTH);
    chk("stall_in_rdy", in_rdy, 0);
    chk("stall_occupancy", occupancy, DEPTH);
    chk("stall_err_overflow", err_overflow, 0);
    out_rdy = 1'b1;
    stream(20 - DEPTH, 100, -1, 200, acc2, drops);
    chk("stall_rest_accepted", acc2, 20 - DEPTH);
    drain(100);
    chk("stall_results", pop_cnt - pop0, 20);

    // Random valid/ready
    max_occ = 0;
    stream(1000, 50, 50, 20000, acc, drops);
    chk("rand_accepted", acc, 1000);
    drain(200);
    chk("rand_err_overflow", err_overflow, 0);
    chk("rand_err_spurious", err_spurious, 0);
    chk("rand_max_occ_le_depth", (max_occ <= DEPTH), 1);

    // Reset with 3 buffered and 5 in flight
    out_rdy = 1'b0;
    stream(3, 100, -1, 20, acc, drops);
    repeat (L + 3) @(posedge clk);
    #1;
    chk("mid_buffered_occ", occupancy, 3);
    chk("mid_buffered_out_vld", out_vld, 1);
    stream(5, 100, -1, 20, acc, drops);
    chk("mid_inflight_accepted", acc, 5);
    chk("mid_occ_full", occupancy, DEPTH);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_vld", out_vld, 0);
    chk("mid_rst_occupancy", occupancy, 0);
    chk("mid_rst_pipe_arg_vld", pipe_arg_vld, 0);
    out_rdy = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_vld = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_vld || pipe_res_vld) seen_vld++;
    end
    chk("mid_rst_no_results", seen_vld, 0);

    // Spurious result with nothing in flight
    @(posedge clk); #1;
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    chk("spur_err_spurious", err_spurious, 1);
    chk("spur_err_overflow", err_overflow, 0);
    chk("spur_out_vld", out_vld, 0);
    chk("spur_occupancy", occupancy, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("spur_sticky", err_spurious, 1);
    rst_n = 1'b0;
    #1;
    chk("spur_cleared_by_reset", err_spurious, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
